// File: rtl/ad_pkg.sv
// Shared types and helpers for the AD channel datapath.
// Sample width, channel-tag sizing and round-robin pointer wrap.
package ad_pkg;

  localparam int AD_DW = 24;

  // Smallest tag width that can name n channels (at least 1 bit).
  function automatic int ch_tag_w(input int n);
    return (n <= 2) ? 1 : $clog2(n);
  endfunction

  function automatic int unsigned rr_next(input int unsigned ptr, input int unsigned n);
    return (ptr == n - 1) ? 0 : ptr + 1;
  endfunction

endpackage

// File: rtl/ad_rr_pick.sv
// Combinational round-robin picker: first set req bit at or after ptr, wrapping.
// Zero latency; no backpressure (pure function of req and ptr).
module ad_rr_pick #(
  parameter int N_CH = 4,
  parameter int CH_W = 3
) (
  input  logic [N_CH-1:0] req,
  input  logic [CH_W-1:0] ptr,
  output logic            gnt_vld,
  output logic [CH_W-1:0] gnt_idx
);

  // Scan from the farthest offset down so the nearest hit to ptr wins.
  always_comb begin
    gnt_vld = 1'b0;
    gnt_idx = '0;
    for (int k = N_CH - 1; k >= 0; k--) begin
      for (int j = 0; j < N_CH; j++) begin
        if (((int'(ptr) + k) % N_CH == j) && req[j]) begin
          gnt_vld = 1'b1;
          gnt_idx = CH_W'(j);
        end
      end
    end
  end

endmodule

// File: rtl/ad_ch_arb.sv
// Round-robin merge of N_CH AD/test-pattern channels into one registered valid/ready port.
// Latency src_vld -> out_vld is 2 cycles; out_rdy low holds the output and 1-deep per-channel holds (overrun sets ovf_flag).
module ad_ch_arb
  import ad_pkg::*;
#(
  parameter int N_CH = 4,
  parameter int CH_W = 3
) (
  input  logic                  clk_sys,
  input  logic                  rst,
  input  logic [AD_DW*N_CH-1:0] ad_data,
  input  logic [N_CH-1:0]       ad_vld,
  input  logic [AD_DW-1:0]      tp_data,
  input  logic                  tp_vld,
  input  logic [7:0]            cfg_ad_tp,
  input  logic [7:0]            cfg_ch_en,
  input  logic                  ovf_clr,
  output logic [AD_DW-1:0]      out_data,
  output logic [CH_W-1:0]       out_ch,
  output logic                  out_vld,
  input  logic                  out_rdy,
  output logic [N_CH-1:0]       ovf_flag,
  output logic                  busy
);

  logic [N_CH-1:0]  src_vld;
  logic [AD_DW-1:0] src_data [N_CH];
  logic [N_CH-1:0]  hold_vld;
  logic [AD_DW-1:0] hold_data [N_CH];
  logic [N_CH-1:0]  req;
  logic [N_CH-1:0]  gnt_oh;
  logic [N_CH-1:0]  ovf_set;
  logic [AD_DW-1:0] gnt_data;
  logic [CH_W-1:0]  rr_ptr;
  logic             pick_vld;
  logic [CH_W-1:0]  pick_idx;
  logic             can_load;
  logic             grant;
  logic             unused_cfg;

  assign unused_cfg = ^{cfg_ad_tp, cfg_ch_en};

  always_comb begin
    for (int i = 0; i < N_CH; i++) begin
      src_vld[i]  = cfg_ch_en[i] & (cfg_ad_tp[i] ? tp_vld : ad_vld[i]);
      src_data[i] = cfg_ad_tp[i] ? tp_data : ad_data[AD_DW*i +: AD_DW];
    end
  end

  // Disabled channels stop requesting immediately so no grant races the clear.
  assign req      = hold_vld & cfg_ch_en[N_CH-1:0];
  assign can_load = ~out_vld | out_rdy;
  assign grant    = pick_vld & can_load;

  ad_rr_pick #(
    .N_CH (N_CH),
    .CH_W (CH_W)
  ) u_pick (
    .req     (req),
    .ptr     (rr_ptr),
    .gnt_vld (pick_vld),
    .gnt_idx (pick_idx)
  );

  always_comb begin
    gnt_data = '0;
    for (int i = 0; i < N_CH; i++) begin
      gnt_oh[i]  = grant && (pick_idx == CH_W'(i));
      ovf_set[i] = src_vld[i] & hold_vld[i] & ~gnt_oh[i];
      if (pick_idx == CH_W'(i)) gnt_data = hold_data[i];
    end
  end

  always_ff @(posedge clk_sys) begin
    for (int i = 0; i < N_CH; i++) begin
      if (src_vld[i]) hold_data[i] <= src_data[i];
    end
  end

  always_ff @(posedge clk_sys) begin
    if (rst) begin
      hold_vld <= '0;
      ovf_flag <= '0;
      out_vld  <= 1'b0;
      out_data <= '0;
      out_ch   <= '0;
      rr_ptr   <= '0;
    end else begin
      for (int i = 0; i < N_CH; i++) begin
        if (!cfg_ch_en[i])   hold_vld[i] <= 1'b0;
        else if (src_vld[i]) hold_vld[i] <= 1'b1;
        else if (gnt_oh[i])  hold_vld[i] <= 1'b0;
        if (ovf_set[i])      ovf_flag[i] <= 1'b1;
        else if (ovf_clr)    ovf_flag[i] <= 1'b0;
      end
      if (can_load) out_vld <= grant;
      if (grant) begin
        out_data <= gnt_data;
        out_ch   <= pick_idx;
        rr_ptr   <= CH_W'(rr_next(32'(pick_idx), N_CH));
      end
    end
  end

  assign busy = (|hold_vld) | out_vld;

endmodule

// File: tb/tb_ad_ch_arb.sv
// Directed bench for ad_ch_arb (N_CH=4): ordering, tp select, backpressure, overrun, fairness, reset.
module tb_ad_ch_arb;

  logic        clk_sys = 1'b0;
  logic        rst;
  logic [95:0] ad_data;
  logic [3:0]  ad_vld;
  logic [23:0] tp_data;
  logic        tp_vld;
  logic [7:0]  cfg_ad_tp;
  logic [7:0]  cfg_ch_en;
  logic        ovf_clr;
  logic [23:0] out_data;
  logic [2:0]  out_ch;
  logic        out_vld;
  logic        out_rdy;
  logic [3:0]  ovf_flag;
  logic        busy;

  int checks   = 0;
  int failures = 0;

  ad_ch_arb #(.N_CH(4), .CH_W(3)) dut (
    .clk_sys   (clk_sys),
    .rst       (rst),
    .ad_data   (ad_data),
    .ad_vld    (ad_vld),
    .tp_data   (tp_data),
    .tp_vld    (tp_vld),
    .cfg_ad_tp (cfg_ad_tp),
    .cfg_ch_en (cfg_ch_en),
    .ovf_clr   (ovf_clr),
    .out_data  (out_data),
    .out_ch    (out_ch),
    .out_vld   (out_vld),
    .out_rdy   (out_rdy),
    .ovf_flag  (ovf_flag),
    .busy      (busy)
  );

  always #5 clk_sys = ~clk_sys;

  task automatic tick;
    @(negedge clk_sys);
  endtask

  task automatic test_reset;
    rst = 1'b1;
    tick;
    tick;
    checks++; if (out_vld !== 1'b0) begin failures++; $display("FAIL reset_out_vld: got %b expected 0", out_vld); end
    checks++; if (busy !== 1'b0) begin failures++; $display("FAIL reset_busy: got %b expected 0", busy); end
    checks++; if (ovf_flag !== 4'h0) begin failures++; $display("FAIL reset_ovf: got %h expected 0", ovf_flag); end
    checks++; if (out_data !== 24'h0 || out_ch !== 3'd0) begin failures++; $display("FAIL reset_out: got data %h ch %0d expected 0/0", out_data, out_ch); end
    rst = 1'b0;
  endtask

  task automatic test_rr_order;
    logic [23:0] exp_d [4];
    exp_d = '{24'h000011, 24'h000022, 24'h000033, 24'h000044};
    ad_data = {24'h000044, 24'h000033, 24'h000022, 24'h000011};
    ad_vld  = 4'b1111;
    tick;
    ad_vld = 4'b0000;
    checks++; if (out_vld !== 1'b0 || busy !== 1'b1) begin failures++; $display("FAIL order_t1: got vld %b busy %b expected 0/1", out_vld, busy); end
    tick;
    for (int k = 0; k < 4; k++) begin
      checks++;
      if (out_vld !== 1'b1 || out_ch !== 3'(k) || out_data !== exp_d[k]) begin
        failures++; $display("FAIL order_out%0d: got vld %b ch %0d data %h expected 1/%0d/%h", k, out_vld, out_ch, out_data, k, exp_d[k]);
      end
      tick;
    end
    checks++; if (out_vld !== 1'b0 || busy !== 1'b0) begin failures++; $display("FAIL order_idle: got vld %b busy %b expected 0/0", out_vld, busy); end
  endtask

  task automatic test_tp_select;
    logic [23:0] exp_d [4];
    exp_d = '{24'h123456, 24'hAAAAAA, 24'h123456, 24'hBBBBBB};
    cfg_ad_tp = 8'h05;
    ad_data = {24'hBBBBBB, 24'hDEAD02, 24'hAAAAAA, 24'hDEAD00};
    tp_data = 24'h123456;
    tp_vld  = 1'b1;
    ad_vld  = 4'b1010;
    tick;
    tp_vld = 1'b0;
    ad_vld = 4'b0000;
    tick;
    for (int k = 0; k < 4; k++) begin
      checks++;
      if (out_vld !== 1'b1 || out_ch !== 3'(k) || out_data !== exp_d[k]) begin
        failures++; $display("FAIL tp_out%0d: got vld %b ch %0d data %h expected 1/%0d/%h", k, out_vld, out_ch, out_data, k, exp_d[k]);
      end
      tick;
    end
    checks++; if (out_vld !== 1'b0) begin failures++; $display("FAIL tp_idle: got vld %b expected 0", out_vld); end
    cfg_ad_tp = 8'h00;
  endtask

  task automatic test_backpressure;
    out_rdy = 1'b0;
    ad_data[48 +: 24] = 24'h000001;
    ad_vld = 4'b0100;
    tick;
    ad_vld = 4'b0000;
    tick;
    checks++; if (out_vld !== 1'b1 || out_ch !== 3'd2 || out_data !== 24'h000001) begin failures++; $display("FAIL bp_first: got vld %b ch %0d data %h expected 1/2/000001", out_vld, out_ch, out_data); end
    ad_data[48 +: 24] = 24'h000002;
    ad_vld = 4'b0100;
    tick;
    ad_vld = 4'b0000;
    for (int k = 0; k < 3; k++) begin
      checks++;
      if (out_vld !== 1'b1 || out_ch !== 3'd2 || out_data !== 24'h000001 || ovf_flag !== 4'h0) begin
        failures++; $display("FAIL bp_stable%0d: got vld %b ch %0d data %h ovf %h expected 1/2/000001/0", k, out_vld, out_ch, out_data, ovf_flag);
      end
      if (k == 2) out_rdy = 1'b1;
      tick;
    end
    checks++; if (out_vld !== 1'b1 || out_data !== 24'h000002) begin failures++; $display("FAIL bp_second: got vld %b data %h expected 1/000002", out_vld, out_data); end
    out_rdy = 1'b0;
    ad_data[48 +: 24] = 24'h000003;
    ad_vld = 4'b0100;
    tick;
    ad_data[48 +: 24] = 24'h000004;
    tick;
    ad_vld = 4'b0000;
    checks++; if (ovf_flag !== 4'b0100) begin failures++; $display("FAIL ovf_set: got %b expected 0100", ovf_flag); end
    checks++; if (out_data !== 24'h000002) begin failures++; $display("FAIL bp_hold2: got %h expected 000002", out_data); end
    ovf_clr = 1'b1;
    tick;
    ovf_clr = 1'b0;
    checks++; if (ovf_flag !== 4'b0000) begin failures++; $display("FAIL ovf_clr: got %b expected 0000", ovf_flag); end
    out_rdy = 1'b1;
    tick;
    checks++; if (out_vld !== 1'b1 || out_data !== 24'h000004) begin failures++; $display("FAIL ovf_overwrite: got vld %b data %h expected 1/000004", out_vld, out_data); end
    tick;
    checks++; if (out_vld !== 1'b0 || busy !== 1'b0) begin failures++; $display("FAIL bp_idle: got vld %b busy %b expected 0/0", out_vld, busy); end
    // clear and a new overrun in the same cycle: the set must win
    out_rdy = 1'b0;
    ad_data[48 +: 24] = 24'h000005;
    ad_vld = 4'b0100;
    tick;
    ad_data[48 +: 24] = 24'h000006;
    tick;
    ad_data[48 +: 24] = 24'h000007;
    ovf_clr = 1'b1;
    tick;
    ad_vld = 4'b0000;
    checks++; if (ovf_flag !== 4'b0100) begin failures++; $display("FAIL ovf_set_wins: got %b expected 0100", ovf_flag); end
    tick;
    ovf_clr = 1'b0;
    checks++; if (ovf_flag !== 4'b0000) begin failures++; $display("FAIL ovf_clr2: got %b expected 0000", ovf_flag); end
    out_rdy = 1'b1;
    tick;
    checks++; if (out_vld !== 1'b1 || out_data !== 24'h000007) begin failures++; $display("FAIL ovf_overwrite2: got vld %b data %h expected 1/000007", out_vld, out_data); end
    tick;
    checks++; if (out_vld !== 1'b0) begin failures++; $display("FAIL bp_idle2: got vld %b expected 0", out_vld); end
  endtask

  task automatic test_back_to_back;
    for (int k = 0; k < 10; k++) begin
      if (k >= 2) begin
        checks++;
        if (out_vld !== 1'b1 || out_ch !== 3'd1 || out_data !== 24'h000100 + 24'(k - 2)) begin
          failures++; $display("FAIL b2b_out%0d: got vld %b ch %0d data %h expected 1/1/%h", k, out_vld, out_ch, out_data, 24'h000100 + 24'(k - 2));
        end
      end
      ad_data[24 +: 24] = 24'h000100 + 24'(k);
      ad_vld = 4'b0010;
      tick;
    end
    ad_vld = 4'b0000;
    tick;
    checks++; if (out_data !== 24'h000109) begin failures++; $display("FAIL b2b_last: got %h expected 000109", out_data); end
    tick;
    checks++; if (ovf_flag !== 4'h0 || out_vld !== 1'b0) begin failures++; $display("FAIL b2b_ovf: got ovf %h vld %b expected 0/0", ovf_flag, out_vld); end
  endtask

  task automatic test_fairness;
    int exp_a [8];
    int exp_b [6];
    exp_a = '{2, 3, 0, 1, 2, 3, 0, 1};
    exp_b = '{3, 0, 1, 3, 0, 1};
    ad_data = {24'hC00003, 24'hC00002, 24'hC00001, 24'hC00000};
    ad_vld  = 4'b1111;
    for (int k = 0; k < 10; k++) begin
      if (k >= 2) begin
        checks++;
        if (out_vld !== 1'b1 || out_ch !== 3'(exp_a[k-2]) || out_data !== 24'hC00000 + 24'(exp_a[k-2])) begin
          failures++; $display("FAIL fair_out%0d: got vld %b ch %0d data %h expected ch %0d", k, out_vld, out_ch, out_data, exp_a[k-2]);
        end
      end
      tick;
    end
    checks++; if (ovf_flag !== 4'hF) begin failures++; $display("FAIL fair_ovf: got %h expected f", ovf_flag); end
    cfg_ch_en = 8'hFB;
    tick;
    for (int k = 0; k < 6; k++) begin
      checks++;
      if (out_vld !== 1'b1 || out_ch !== 3'(exp_b[k])) begin
        failures++; $display("FAIL fair_dis%0d: got vld %b ch %0d expected 1/%0d", k, out_vld, out_ch, exp_b[k]);
      end
      tick;
    end
    cfg_ch_en = 8'hFF;
  endtask

  task automatic test_reset_mid;
    out_rdy = 1'b0;
    tick;
    tick;
    checks++; if (out_vld !== 1'b1 || busy !== 1'b1) begin failures++; $display("FAIL mid_pre: got vld %b busy %b expected 1/1", out_vld, busy); end
    rst = 1'b1;
    ad_vld = 4'b0000;
    tick;
    checks++; if (out_vld !== 1'b0 || busy !== 1'b0 || ovf_flag !== 4'h0) begin failures++; $display("FAIL mid_rst: got vld %b busy %b ovf %h expected 0/0/0", out_vld, busy, ovf_flag); end
    rst = 1'b0;
    out_rdy = 1'b1;
    ad_vld = 4'b1111;
    tick;
    ad_vld = 4'b0000;
    tick;
    checks++; if (out_vld !== 1'b1 || out_ch !== 3'd0 || out_data !== 24'hC00000) begin failures++; $display("FAIL mid_first: got vld %b ch %0d data %h expected 1/0/c00000", out_vld, out_ch, out_data); end
    tick;
    checks++; if (out_ch !== 3'd1) begin failures++; $display("FAIL mid_second: got ch %0d expected 1", out_ch); end
    tick;
    tick;
    tick;
    checks++; if (out_vld !== 1'b0 || busy !== 1'b0) begin failures++; $display("FAIL mid_idle: got vld %b busy %b expected 0/0", out_vld, busy); end
  endtask

  initial begin
    rst       = 1'b1;
    ad_data   = '0;
    ad_vld    = 4'b0000;
    tp_data   = '0;
    tp_vld    = 1'b0;
    cfg_ad_tp = 8'h00;
    cfg_ch_en = 8'hFF;
    ovf_clr   = 1'b0;
    out_rdy   = 1'b1;
    test_reset;
    test_rr_order;
    test_tp_select;
    test_backpressure;
    test_back_to_back;
    test_fairness;
    test_reset_mid;
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
